// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encodings, default bus widths and
// the slave address map decoded on addr[7:5].
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_M0 = 2'b01,
    GNT_M1 = 2'b10
  } arb_state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  // Slave regions selected by address bits [7:5]
  localparam logic [2:0] S0_BASE = 3'b000;  // 0x00-0x1F
  localparam logic [2:0] S1_BASE = 3'b001;  // 0x20-0x3F

endpackage

// File: rtl/bus_mux2.sv
// Master-side 2:1 mux of {wr, address, data}. sel is one-hot:
// sel[0] selects input a, sel[1] selects input b, sel=0 drives all zero.
module bus_mux2 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        sel,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_data,
  output logic              y_wr,
  output logic [ADDR_W-1:0] y_address,
  output logic [DATA_W-1:0] y_data
);

  // AND-OR select so an idle bus (sel=0) reads back as all zero
  always_comb begin
    y_wr      = (sel[0] & a_wr) | (sel[1] & b_wr);
    y_address = ({ADDR_W{sel[0]}} & a_address) | ({ADDR_W{sel[1]}} & b_address);
    y_data    = ({DATA_W{sel[0]}} & a_data)    | ({DATA_W{sel[1]}} & b_data);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with Moore grants and the master-side mux.
// Default build: fixed priority (M0 wins ties), owner keeps the bus until it
// drops its request. With BUS_ARB_FAIR_EN defined: ties go to the master not
// granted last, and an owner is preempted after MAX_HOLD cycles of contention.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M0_grant,
  output logic              M1_grant,
  output logic              S_wr,
  output logic [ADDR_W-1:0] S_address,
  output logic [DATA_W-1:0] S_din
);

  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("bus_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_e state_q, state_d;
  logic       tie_to_m1;
  logic       preempt;

`ifdef BUS_ARB_FAIR_EN
  localparam int                HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic              last_m1_q, last_m1_d;   // 1: last grant went to M1
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  // Round-robin tie break and contention preemption
  always_comb begin
    tie_to_m1 = ~last_m1_q;
    preempt   = M0_req & M1_req & (hold_cnt_q == HOLD_MAX);
  end

  // last_grant tracks grant entries; hold_cnt restarts on every state change
  always_comb begin
    last_m1_d  = last_m1_q;
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q) begin
      hold_cnt_d = '0;
      if (state_d == GNT_M0) last_m1_d = 1'b0;
      if (state_d == GNT_M1) last_m1_d = 1'b1;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Fairness state registers; reset leaves M1 as the last owner
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_m1_q  <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      last_m1_q  <= last_m1_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  // Fixed priority, no preemption
  always_comb begin
    tie_to_m1 = 1'b0;
    preempt   = 1'b0;
  end
`endif

  // Next-state logic; a dropping owner hands over directly, no idle bubble
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (M0_req && M1_req) state_d = tie_to_m1 ? GNT_M1 : GNT_M0;
        else if (M0_req)      state_d = GNT_M0;
        else if (M1_req)      state_d = GNT_M1;
      end
      GNT_M0: begin
        if (!M0_req)      state_d = M1_req ? GNT_M1 : IDLE;
        else if (preempt) state_d = GNT_M1;
      end
      GNT_M1: begin
        if (!M1_req)      state_d = M0_req ? GNT_M0 : IDLE;
        else if (preempt) state_d = GNT_M0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset returns the bus to IDLE even mid-transfer
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Moore grants decoded straight from state, mutually exclusive by encoding
  always_comb begin
    M0_grant = (state_q == GNT_M0);
    M1_grant = (state_q == GNT_M1);
  end

  bus_mux2 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel       ({M1_grant, M0_grant}),
    .a_wr      (M0_wr),
    .a_address (M0_address),
    .a_data    (M0_dout),
    .b_wr      (M1_wr),
    .b_address (M1_address),
    .b_data    (M1_dout),
    .y_wr      (S_wr),
    .y_address (S_address),
    .y_data    (S_din)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Expectations follow BUS_ARB_FAIR_EN when defined.
module tb_bus_arbiter;

`ifdef BUS_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        M0_req, M0_wr, M1_req, M1_wr;
  logic [7:0]  M0_address, M1_address;
  logic [31:0] M0_dout, M1_dout;
  logic        M0_grant, M1_grant, S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_HOLD(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .M0_req     (M0_req),
    .M0_wr      (M0_wr),
    .M0_address (M0_address),
    .M0_dout    (M0_dout),
    .M1_req     (M1_req),
    .M1_wr      (M1_wr),
    .M1_address (M1_address),
    .M1_dout    (M1_dout),
    .M0_grant   (M0_grant),
    .M1_grant   (M1_grant),
    .S_wr       (S_wr),
    .S_address  (S_address),
    .S_din      (S_din)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".m0g"},  32'(M0_grant),  32'h0);
    chk({tag, ".m1g"},  32'(M1_grant),  32'h0);
    chk({tag, ".swr"},  32'(S_wr),      32'h0);
    chk({tag, ".sadr"}, 32'(S_address), 32'h0);
    chk({tag, ".sdin"}, S_din,          32'h0);
  endtask

  initial begin
    logic first_m1;
    logic exp_m1;

    // 1: reset held two edges with both masters requesting
    reset_n = 1'b0;
    M0_req = 1'b1; M0_wr = 1'b1; M0_address = 8'h3A; M0_dout = 32'h12345678;
    M1_req = 1'b1; M1_wr = 1'b1; M1_address = 8'h2C; M1_dout = 32'hDEADBEEF;
    step();
    step();
    chk_idle("reset");

    // 2: single M0 request, bus routed in the grant cycle
    reset_n = 1'b1;
    M1_req = 1'b0;
    M0_address = 8'h1F; M0_wr = 1'b1; M0_dout = 32'h000000A5;
    step();
    chk("m0only.m0g",  32'(M0_grant),  32'h1);
    chk("m0only.m1g",  32'(M1_grant),  32'h0);
    chk("m0only.sadr", 32'(S_address), 32'h1F);
    chk("m0only.sdin", S_din,          32'hA5);
    chk("m0only.swr",  32'(S_wr),      32'h1);

    // 6a: owner drops, other idle -> IDLE
    M0_req = 1'b0;
    step();
    chk_idle("drop");

    // 3/6b: tie from IDLE (fair build: M0 owned last, so M1 wins)
    M0_address = 8'h05; M0_wr = 1'b0; M0_dout = 32'h11111111;
    M1_address = 8'h2C; M1_wr = 1'b1; M1_dout = 32'hDEADBEEF;
    M0_req = 1'b1; M1_req = 1'b1;
    first_m1 = FAIR;
    step();
    chk("tie.m0g",  32'(M0_grant),  32'(!first_m1));
    chk("tie.m1g",  32'(M1_grant),  32'(first_m1));
    chk("tie.sadr", 32'(S_address), first_m1 ? 32'h2C : 32'h05);

    // winner drops while the other still requests -> direct handoff
    if (first_m1) M1_req = 1'b0; else M0_req = 1'b0;
    step();
    chk("hand.m0g",  32'(M0_grant),  32'(first_m1));
    chk("hand.m1g",  32'(M1_grant),  32'(!first_m1));
    chk("hand.sadr", 32'(S_address), first_m1 ? 32'h05 : 32'h2C);
    chk("hand.sdin", S_din,          first_m1 ? 32'h11111111 : 32'hDEADBEEF);

    // 4: sustained contention from a fresh reset (last owner M1 -> M0 first)
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    M0_req = 1'b1; M1_req = 1'b1;
    step();
    for (int k = 0; k < 100; k++) begin
      exp_m1 = FAIR && (((k / 8) % 2) == 1);
      chk($sformatf("hold%0d.m0g", k), 32'(M0_grant), 32'(!exp_m1));
      chk($sformatf("hold%0d.m1g", k), 32'(M1_grant), 32'(exp_m1));
      chk($sformatf("hold%0d.sdin", k), S_din, exp_m1 ? 32'hDEADBEEF : 32'h11111111);
      step();
    end

    // 5: M1 owns the bus, reset mid-transfer, then regrant
    M0_req = 1'b0;
    step();
    chk("m1own.m0g", 32'(M0_grant), 32'h0);
    chk("m1own.m1g", 32'(M1_grant), 32'h1);
    reset_n = 1'b0;
    step();
    chk_idle("midrst");
    reset_n = 1'b1;
    step();
    chk("regnt.m1g",  32'(M1_grant),  32'h1);
    chk("regnt.m0g",  32'(M0_grant),  32'h0);
    chk("regnt.sadr", 32'(S_address), 32'h2C);
    chk("regnt.swr",  32'(S_wr),      32'h1);
    chk("regnt.sdin", S_din,          32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
